// File: rtl/func_seq_pkg.sv
// Shared types and widths for the func sequencer.
// State encoding, operand/result widths and the timeout result marker.
package func_seq_pkg;

   localparam int X_W = 8;
   localparam int Y_W = 16;
   localparam logic [Y_W-1:0] ERR_Y = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT_BUSY,
      ST_WAIT_DONE
   } state_e;

endpackage

// File: rtl/func_seq_fifo.sv
// Synchronous result FIFO with combinational head.
// Pointers wrap modulo DEPTH; pop when empty is ignored.
module func_seq_fifo #(
   parameter int W     = 24,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          pop_i,
   output logic [W-1:0]  rdata_o,
   output logic          valid_o,
   output logic [CW-1:0] count_o
);

   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push;
   logic          do_pop;

   always_comb begin
      do_push = push_i && (count_q != FULL);
      do_pop  = pop_i && (count_q != '0);
      mem_d   = mem_q;
      if (do_push) mem_d[wptr_q] = wdata_i;
      wptr_d  = wptr_q + AW'(do_push);
      rptr_d  = rptr_q + AW'(do_pop);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q   <= '{default: '0};
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   assign rdata_o = mem_q[rptr_q];
   assign valid_o = (count_q != '0);
   assign count_o = count_q;

endmodule

// File: rtl/func_seq.sv
// Sequencer feeding one sample at a time to func and buffering {x, y}.
// Optional watchdog enabled by FUNC_SEQ_TIMEOUT_EN.
module func_seq
   import func_seq_pkg::*;
#(
   parameter int OUT_DEPTH = 4,
   parameter int TO_CYCLES = 64
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid_i,
   output logic           in_ready_o,
   input  logic [X_W-1:0] in_data_i,
   output logic           f_start_o,
   output logic [X_W-1:0] f_x_o,
   input  logic           f_busy_i,
   input  logic [Y_W-1:0] f_y_i,
   output logic           out_valid_o,
   input  logic           out_ready_i,
   output logic [X_W-1:0] out_x_o,
   output logic [Y_W-1:0] out_y_o,
   output logic           err_o
);

   localparam int AW = $clog2(OUT_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(OUT_DEPTH);

   state_e         state_q, state_d;
   logic [X_W-1:0] x_q, x_d;
   logic           start_q, start_d;
   logic           rdy_q, rdy_d;
   logic           push;
   logic [Y_W-1:0] push_y;
   logic           pop;
   logic           out_valid;
   logic [CW-1:0]  count;
   logic [CW-1:0]  cnt_nxt;
   logic [X_W+Y_W-1:0] head;

`ifdef FUNC_SEQ_TIMEOUT_EN
   localparam int WW = $clog2(TO_CYCLES + 1);
   localparam logic [WW-1:0] WD_LIM = WW'(TO_CYCLES - 1);
   logic [WW-1:0] wd_q, wd_d;
   logic          err_q, err_d;
`endif

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      start_d = 1'b0;
      push    = 1'b0;
      push_y  = f_y_i;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid_i && rdy_q) begin
               x_d     = in_data_i;
               start_d = 1'b1;
               state_d = ST_LAUNCH;
            end
         end
         ST_LAUNCH:    state_d = ST_WAIT_BUSY;
         ST_WAIT_BUSY: if (f_busy_i) state_d = ST_WAIT_DONE;
         ST_WAIT_DONE: begin
            if (!f_busy_i) begin
               push    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
`ifdef FUNC_SEQ_TIMEOUT_EN
      err_d = err_q;
      wd_d  = '0;
      if ((state_q == ST_WAIT_BUSY || state_q == ST_WAIT_DONE) && !push) begin
         if (wd_q == WD_LIM) begin
            push    = 1'b1;
            push_y  = ERR_Y;
            err_d   = 1'b1;
            state_d = ST_IDLE;
         end else begin
            wd_d = wd_q + 1'b1;
         end
      end
`endif
      pop     = out_valid && out_ready_i;
      cnt_nxt = count + CW'(push) - CW'(pop);
      // A slot is reserved at accept, so the later push never overflows
      rdy_d   = (state_d == ST_IDLE) && (cnt_nxt < FULL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         start_q <= 1'b0;
         rdy_q   <= 1'b0;
`ifdef FUNC_SEQ_TIMEOUT_EN
         wd_q    <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         start_q <= start_d;
         rdy_q   <= rdy_d;
`ifdef FUNC_SEQ_TIMEOUT_EN
         wd_q    <= wd_d;
         err_q   <= err_d;
`endif
      end
   end

   func_seq_fifo #(
      .W     (X_W + Y_W),
      .DEPTH (OUT_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .wdata_i ({x_q, push_y}),
      .pop_i   (pop),
      .rdata_o (head),
      .valid_o (out_valid),
      .count_o (count)
   );

   assign in_ready_o  = rdy_q;
   assign f_start_o   = start_q;
   assign f_x_o       = x_q;
   assign out_valid_o = out_valid;
   assign out_x_o     = head[X_W+Y_W-1:Y_W];
   assign out_y_o     = head[Y_W-1:0];
`ifdef FUNC_SEQ_TIMEOUT_EN
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_func_seq.sv
// Bench for func_seq: stub func, scoreboard queue, directed and random traffic.
module tb_func_seq;

   localparam int DEPTH = 4;
   localparam int TO    = 64;
   localparam int B     = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [7:0]  in_data_i = '0;
   logic        f_start_o;
   logic [7:0]  f_x_o;
   logic        f_busy_i;
   logic [15:0] f_y_i;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic [7:0]  out_x_o;
   logic [15:0] out_y_o;
   logic        err_o;

   always #5 clk = ~clk;

   func_seq #(.OUT_DEPTH(DEPTH), .TO_CYCLES(TO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   (in_data_i),
      .f_start_o   (f_start_o),
      .f_x_o       (f_x_o),
      .f_busy_i    (f_busy_i),
      .f_y_i       (f_y_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_x_o     (out_x_o),
      .out_y_o     (out_y_o),
      .err_o       (err_o)
   );

   int n_run = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] fx(input logic [7:0] x);
      return {x, x + 8'h22};
   endfunction

   // Stub func: mode 0 normal (busy B cycles), 1 never busy, 2 busy forever
   int          mode = 0;
   logic        st_busy;
   logic [15:0] st_y;
   int          st_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_busy <= 1'b0;
         st_y    <= '0;
         st_cnt  <= 0;
      end else if (f_start_o && mode != 1) begin
         st_busy <= 1'b1;
         st_cnt  <= B;
         st_y    <= fx(f_x_o);
      end else if (st_busy && mode == 0) begin
         if (st_cnt == 1) st_busy <= 1'b0;
         st_cnt <= st_cnt - 1;
      end
   end

   assign f_busy_i = st_busy;
   assign f_y_i    = st_y;

   logic [23:0] exp_q[$];
   int          acc_n = 0;
   int          pop_n = 0;
   int          start_n = 0;
   logic        start_prev = 1'b0;
   logic [7:0]  last_x = '0;
   bit          have_x = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         start_prev = 1'b0;
         have_x = 0;
      end else begin
         if (have_x) chk("fx_stable", f_x_o, last_x);
         if (in_valid_i && in_ready_o) begin
            acc_n++;
            last_x = in_data_i;
            have_x = 1;
            exp_q.push_back({in_data_i, (mode == 1) ? 16'hFFFF : fx(in_data_i)});
         end
         if (f_start_o) begin
            start_n++;
            chk("start_1cyc", start_prev, 0);
         end
         start_prev = f_start_o;
         if (out_valid_o && out_ready_i) begin
            pop_n++;
            if (exp_q.size() == 0) begin
               chk("pop_unexpected", exp_q.size(), 1);
            end else begin
               logic [23:0] e;
               e = exp_q.pop_front();
               chk("out_x", out_x_o, e[23:16]);
               chk("out_y", out_y_o, e[15:0]);
            end
         end
      end
   end

   task automatic send(input logic [7:0] x);
      in_data_i  = x;
      in_valid_i = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (in_ready_o) begin
            @(posedge clk);
            #1;
            in_valid_i = 1'b0;
            return;
         end
      end
      chk("send_timeout", in_ready_o, 1);
      in_valid_i = 1'b0;
   endtask

   task automatic drain(input int n);
      int target;
      target = pop_n + n;
      out_ready_i = 1'b1;
      for (int i = 0; i < 300 && pop_n < target; i++) begin
         @(posedge clk);
         #1;
      end
      out_ready_i = 1'b0;
      chk("drain_cnt", pop_n, target);
   endtask

   task automatic wait_valid(output int lat, input int limit);
      lat = 1;
      while (!out_valid_o && lat < limit) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench hung");
   end

   bit burst_done;
   int a0, s0, p0, lat, target;

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready_o, 0);
      chk("rst_out_valid", out_valid_o, 0);
      chk("rst_start", f_start_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_fx", f_x_o, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // single job and its latency
      mode = 0;
      s0 = start_n;
      send(8'h12);
      wait_valid(lat, 50);
      chk("t1_latency", lat, B + 3);
      chk("t1_x", out_x_o, 8'h12);
      chk("t1_y", out_y_o, 16'h1234);
      chk("t1_err", err_o, 0);
      chk("t1_starts", start_n - s0, 1);
      drain(1);

      // burst into a blocked output
      a0 = acc_n;
      burst_done = 0;
      fork
         begin
            for (int i = 0; i < 6; i++) send(8'($urandom));
            burst_done = 1;
         end
      join_none
      repeat (80) @(posedge clk);
      #1;
      chk("t2_accepted_full", acc_n - a0, DEPTH);
      chk("t2_in_ready_full", in_ready_o, 0);
      chk("t2_out_valid", out_valid_o, 1);
      drain(6);
      for (int i = 0; i < 100 && !burst_done; i++) @(posedge clk);
      #1;
      chk("t2_sender_done", burst_done, 1);
      chk("t2_accepted", acc_n - a0, 6);
      chk("t2_sb_empty", exp_q.size(), 0);

      // pop in the same cycle as a push
      for (int i = 0; i < 3; i++) send(8'($urandom));
      send(8'hC3);
      for (int i = 0; i < 20 && !f_busy_i; i++) begin
         @(posedge clk);
         #1;
      end
      for (int i = 0; i < 20 && f_busy_i; i++) begin
         @(posedge clk);
         #1;
      end
      p0 = pop_n;
      out_ready_i = 1'b1;
      @(posedge clk);
      #1;
      out_ready_i = 1'b0;
      chk("t3_one_pop", pop_n - p0, 1);
      repeat (2) @(posedge clk);
      #1;
      chk("t3_ready_after", in_ready_o, 1);
      chk("t3_backlog", exp_q.size(), 3);
      drain(3);
      @(posedge clk);
      #1;
      chk("t3_empty", out_valid_o, 0);

      // reset in the middle of a job
      send(8'h77);
      for (int i = 0; i < 20 && !f_busy_i; i++) begin
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t4_start", f_start_o, 0);
      chk("t4_out_valid", out_valid_o, 0);
      chk("t4_in_ready", in_ready_o, 0);
      chk("t4_err", err_o, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      send(8'hA5);
      drain(1);
      chk("t4_sb_empty", exp_q.size(), 0);

`ifdef FUNC_SEQ_TIMEOUT_EN
      // watchdog
      mode = 1;
      send(8'h55);
      wait_valid(lat, 200);
      chk("t5_latency", lat, TO + 2);
      chk("t5_x", out_x_o, 8'h55);
      chk("t5_y", out_y_o, 16'hFFFF);
      chk("t5_err", err_o, 1);
      drain(1);
      mode = 0;
      send(8'h31);
      drain(1);
      chk("t5_err_sticky", err_o, 1);
      do_reset();
      chk("t5_err_cleared", err_o, 0);
`endif

      // func stays busy: no relaunch, operand held
      mode = 2;
      s0 = start_n;
      send(8'h3C);
      repeat (40) @(posedge clk);
      #1;
      chk("t6_starts", start_n - s0, 1);
      chk("t6_fx", f_x_o, 8'h3C);
      chk("t6_in_ready", in_ready_o, 0);
      chk("t6_out_valid", out_valid_o, 0);
      mode = 0;
      do_reset();

      // random traffic
      a0 = acc_n;
      s0 = start_n;
      target = pop_n + 40;
      burst_done = 0;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               #1;
               send(8'($urandom));
            end
            burst_done = 1;
         end
      join_none
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         if (pop_n >= target) break;
         out_ready_i = 1'($urandom_range(0, 1));
      end
      out_ready_i = 1'b0;
      chk("rnd_pops", pop_n, target);
      chk("rnd_sender_done", burst_done, 1);
      chk("rnd_accepts", acc_n - a0, 40);
      chk("rnd_starts", start_n - s0, 40);
      chk("rnd_sb_empty", exp_q.size(), 0);
      chk("rnd_err", err_o, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
